// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the loader FSM encoding and the default geometry of the instruction store.
// Imported by the loader top level and its RAM.
package imem_loader_pkg;

    localparam int DEFAULT_ADDR_W = 7;
    localparam int DEFAULT_WORD_W = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: DEPTH x WORD_W array, one synchronous write port, one async read port.
// Latency: write lands on the clock edge with we high; read is combinational.
// Backpressure: none; the array accepts a write every cycle and is never reset.
module imem_ram #(
    parameter int ADDR_W = 7,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Write port: contents are deliberately left uninitialised; readers mask stale words.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a framed big-endian byte stream into the instruction RAM, verifies XOR checksum.
// Latency: one WRITE cycle after every 4th data byte (4 bytes / 5 cycles); status valid the cycle after checksum.
// Backpressure: byte_ready low in WRITE, DONE and ERROR; fetch output is combinational and NOP-masked until DONE.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] instruction,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_error
);

    // Counters carry one extra bit so a full 2**ADDR_W-word image is representable.
    localparam int CNT_W = ADDR_W + 1;

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_ptr;
    logic [1:0]        r_idx;
    logic [7:0]        r_xor;
    logic [WORD_W-1:0] r_asm;

    logic              w_xfer;
    logic              w_we;
    logic [CNT_W-1:0]  w_ptr_inc;
    logic [CNT_W-1:0]  w_hdr_n;
    logic [WORD_W-1:0] w_rdata;

    assign w_xfer    = byte_valid && byte_ready;
    assign w_ptr_inc = r_ptr + CNT_W'(1);
    // Header byte encodes N-1; only the low ADDR_W bits are meaningful.
    assign w_hdr_n   = CNT_W'(byte_data[ADDR_W-1:0]) + CNT_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; decisions use byte_valid since ready is implied by the state.
    always_comb begin
        w_state_nxt = r_state;
        byte_ready  = 1'b0;
        cpu_rst     = 1'b1;
        load_done   = 1'b0;
        load_error  = 1'b0;
        w_we        = 1'b0;
        unique case (r_state)
            S_HDR: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && (r_idx == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_we        = 1'b1;
                w_state_nxt = (w_ptr_inc == r_n) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_state_nxt = (byte_data == r_xor) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
            end
            S_ERROR: begin
                load_error = 1'b1;
            end
            default: begin
                w_state_nxt = S_HDR;
            end
        endcase
    end

    // Datapath: word count, byte index, word pointer, running XOR and big-endian assembly register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n   <= '0;
            r_ptr <= '0;
            r_idx <= '0;
            r_xor <= '0;
            r_asm <= '0;
        end else begin
            unique case (r_state)
                S_HDR: begin
                    if (w_xfer) begin
                        r_n   <= w_hdr_n;
                        r_idx <= '0;
                        r_ptr <= '0;
                        r_xor <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm <= {r_asm[WORD_W-9:0], byte_data};
                        r_xor <= r_xor ^ byte_data;
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_ptr <= w_ptr_inc;
                end
                default: begin
                end
            endcase
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_ptr[ADDR_W-1:0]),
        .wdata (r_asm),
        .raddr (address),
        .rdata (w_rdata)
    );

    // Fetch returns a NOP unless the image is verified and the address lies inside it.
    assign instruction = ((r_state == S_DONE) && ({1'b0, address} < r_n)) ? w_rdata : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level reference model.
// Model tracks bytes consumed per frame, the stall after each completed word, and the image.
// Outputs compared every negedge; literal checks pin the model on the documented frames.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [6:0]  address;
    logic [31:0] instruction;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: frame-level view of the loader.
    bit          m_done, m_err, m_stall, m_xfer;
    int          m_cnt, m_n;
    logic [7:0]  m_xor;
    logic [31:0] m_word;
    logic [31:0] m_img [128];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .address     (address),
        .instruction (instruction),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy();
        return !m_stall && !m_done && !m_err;
    endfunction

    function automatic logic [31:0] m_fetch(input logic [6:0] a);
        if (m_done && (int'(a) < m_n)) return m_img[a];
        return 32'h0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        m_xfer = 1'b0;
        if (rst) begin
            m_done = 0; m_err = 0; m_stall = 0;
            m_cnt = 0; m_n = 0; m_xor = 8'h0; m_word = 32'h0;
        end else if (m_stall) begin
            m_stall = 1'b0;
        end else if (m_rdy() && byte_valid) begin
            m_xfer = 1'b1;
            if (m_cnt == 0) begin
                m_n   = int'(byte_data[6:0]) + 1;
                m_xor = 8'h0;
            end else if (m_cnt <= 4 * m_n) begin
                m_word = {m_word[23:0], byte_data};
                m_xor  = m_xor ^ byte_data;
                if ((m_cnt - 1) % 4 == 3) begin
                    m_img[(m_cnt - 1) / 4] = m_word;
                    m_stall = 1'b1;
                end
            end else begin
                if (byte_data == m_xor) m_done = 1'b1;
                else m_err = 1'b1;
            end
            m_cnt++;
        end
    endtask

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready",  {31'h0, byte_ready}, {31'h0, m_rdy()});
            chk("cpu_rst",     {31'h0, cpu_rst},    {31'h0, !m_done});
            chk("load_done",   {31'h0, load_done},  {31'h0, m_done});
            chk("load_error",  {31'h0, load_error}, {31'h0, m_err});
            chk("instruction", instruction, m_fetch(address));
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin
            address = 7'($urandom);
            step();
        end
    endtask

    task automatic extra(input int n);
        repeat (n) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            address    = 7'($urandom);
            step();
        end
        byte_valid = 1'b0;
    endtask

    // Drive a byte list; a byte advances only when the model says it was accepted.
    task automatic send(input bq_t q, input int pct);
        int i = 0;
        int guard = 0;
        while (i < q.size() && guard < 20000) begin
            byte_valid = ($urandom_range(99) < pct);
            byte_data  = byte_valid ? q[i] : 8'($urandom);
            address    = 7'($urandom);
            step();
            if (m_xfer) i++;
            guard++;
        end
        byte_valid = 1'b0;
        if (i < q.size()) begin
            total++;
            bad++;
            $display("FAIL send_timeout: sent %0d of %0d bytes", i, q.size());
        end
    endtask

    function automatic bq_t build(input wq_t w, input bit corrupt);
        bq_t f;
        logic [7:0] x = 8'h0;
        f.push_back(8'(w.size() - 1));
        foreach (w[k]) begin
            for (int b = 3; b >= 0; b--) begin
                f.push_back(w[k][b*8 +: 8]);
                x = x ^ w[k][b*8 +: 8];
            end
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        f.push_back(x);
        return f;
    endfunction

    task automatic peek(input string name, input logic [6:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, instruction, exp);
    endtask

    initial begin
        bq_t  good, badf, beef, f;
        wq_t  w;
        int   n;
        foreach (m_img[k]) m_img[k] = 32'h0;
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h0; address = 7'h0;
        m_done = 0; m_err = 0; m_stall = 0; m_xfer = 0;
        m_cnt = 0; m_n = 0; m_xor = 8'h0; m_word = 32'h0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ready", {31'h0, byte_ready}, 32'h1);
        chk("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        chk("rst_done", {31'h0, load_done}, 32'h0);
        peek("rst_instr0", 7'd0, 32'h0);
        peek("rst_instr127", 7'd127, 32'h0);

        // Documented good 2-word frame.
        good = '{8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00, 8'hAA};
        send(good, 100);
        idle(2);
        chk("good_done", {31'h0, load_done}, 32'h1);
        chk("good_cpu_rst", {31'h0, cpu_rst}, 32'h0);
        peek("good_a0", 7'd0, 32'h20010005);
        peek("good_a1", 7'd1, 32'h8C020000);
        peek("good_a2", 7'd2, 32'h0);

        // Same frame, wrong checksum; trailing bytes must be refused.
        do_reset();
        badf = good;
        badf[9] = 8'hAB;
        send(badf, 100);
        chk("bad_error", {31'h0, load_error}, 32'h1);
        chk("bad_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        chk("bad_ready", {31'h0, byte_ready}, 32'h0);
        peek("bad_a0", 7'd0, 32'h0);
        extra(10);
        chk("bad_sticky", {31'h0, load_error}, 32'h1);

        // Continuous valid: stall cycle after each word is checked by the model each cycle.
        do_reset();
        w = {};
        for (int k = 0; k < 6; k++) w.push_back($urandom);
        send(build(w, 1'b0), 100);
        idle(2);
        peek("bp_a5", 7'd5, w[5]);

        // Reset after the 6th data byte, then a fresh 1-word frame.
        do_reset();
        f = good;
        f = f[0:6];
        send(f, 100);
        do_reset();
        beef = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send(beef, 100);
        idle(1);
        peek("mid_a0", 7'd0, 32'hDEADBEEF);
        peek("mid_a1", 7'd1, 32'h0);

        // Full 128-word image; checksum is zero since each word repeats one byte.
        do_reset();
        w = {};
        for (int k = 0; k < 128; k++) w.push_back(32'(k) * 32'h01010101);
        f = build(w, 1'b0);
        chk("full_csum_byte", {24'h0, f[f.size()-1]}, 32'h0);
        send(f, 100);
        idle(1);
        peek("full_a127", 7'd127, 32'h7F7F7F7F);
        extra(20);
        peek("full_a127_after", 7'd127, 32'h7F7F7F7F);
        peek("full_a5_after", 7'd5, 32'h05050505);

        // Random frames, random gaps, occasional bad checksum and mid-frame reset.
        repeat (24) begin
            do_reset();
            n = ($urandom_range(0, 7) == 0) ? 128 : $urandom_range(1, 20);
            w = {};
            for (int k = 0; k < n; k++) w.push_back($urandom);
            f = build(w, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                bq_t p;
                p = f[0:$urandom_range(1, f.size() - 2)];
                send(p, $urandom_range(30, 100));
                do_reset();
            end
            send(f, $urandom_range(30, 100));
            idle(4);
            if ($urandom_range(0, 1) == 1) extra(6);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
